// File: rtl/systolic_tile_sequencer.sv
// Job sequencer for a BM_NUM x BN_NUM systolic tile: clear, stream K-passes, drain, settle, done.
// Optional busy-cycle counter is built only when SEQ_PERF_CNT_EN is defined.
module systolic_tile_sequencer #(
  parameter int BM_NUM   = 4,
  parameter int BN_NUM   = 4,
  parameter int ACCU_NUM = 5,
  parameter int ADDR_W   = 10,
  parameter int PASS_W   = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [PASS_W-1:0] cfg_passes,
  input  logic [ADDR_W-1:0] cfg_act_base,
  input  logic [ADDR_W-1:0] cfg_wet_base,
  input  logic [7:0]        cfg_shift,
  output logic              busy,
  output logic              done,
  output logic              act_rd_en,
  output logic [ADDR_W-1:0] act_rd_addr,
  output logic              wet_rd_en,
  output logic [ADDR_W-1:0] wet_rd_addr,
  output logic              PE_mac_enable,
  output logic              PE_clear_acc,
  output logic              PE_weight_partial_sel,
  output logic [7:0]        PE_res_shift_num,
  output logic              result_valid,
  output logic [31:0]       perf_busy_cycles
);

  localparam int DRAIN_LEN = ACCU_NUM + BN_NUM + BM_NUM + 1;
  localparam int BEAT_W    = $clog2(DRAIN_LEN);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    NEXT   = 3'd4,
    SETTLE = 3'd5,
    DONE   = 3'd6
  } state_t;

  state_t              state_r, state_s;
  logic [PASS_W-1:0]   pass_r, pass_s, passes_r, passes_s, pass_inc_s;
  logic [BEAT_W-1:0]   beat_r, beat_s;
  logic [ADDR_W-1:0]   act_base_r, act_base_s, wet_base_r, wet_base_s;
  logic [7:0]          shift_r, shift_s;
  logic                start_accept_s, abort_hit_s;

  logic                busy_r, done_r, rd_en_r, mac_r, clear_r, sel_r;
  logic [ADDR_W-1:0]   act_addr_r, wet_addr_r;
  logic                busy_s, done_s, rd_en_s, mac_s, clear_s, sel_s;
  logic [ADDR_W-1:0]   act_addr_s, wet_addr_s;

  assign start_accept_s = (state_r == IDLE) && start;
  assign abort_hit_s    = (state_r != IDLE) && abort;
  assign pass_inc_s     = pass_r + PASS_W'(1);

  // Next-state, pass/beat counters and configuration latching
  always_comb begin
    state_s    = state_r;
    pass_s     = pass_r;
    beat_s     = beat_r;
    passes_s   = passes_r;
    act_base_s = act_base_r;
    wet_base_s = wet_base_r;
    shift_s    = shift_r;
    if (abort_hit_s) begin
      state_s = IDLE;
      pass_s  = '0;
      beat_s  = '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_s    = CLEAR;
            pass_s     = '0;
            beat_s     = '0;
            passes_s   = (cfg_passes == '0) ? PASS_W'(1) : cfg_passes;
            act_base_s = cfg_act_base;
            wet_base_s = cfg_wet_base;
            shift_s    = cfg_shift;
          end else begin
            state_s = IDLE;
          end
        end
        CLEAR: begin
          state_s = STREAM;
          beat_s  = '0;
        end
        STREAM: begin
          if (beat_r == BEAT_W'(BN_NUM - 1)) begin
            state_s = DRAIN;
            beat_s  = '0;
          end else begin
            beat_s = beat_r + BEAT_W'(1);
          end
        end
        DRAIN: begin
          if (beat_r == BEAT_W'(DRAIN_LEN - 1)) begin
            state_s = NEXT;
            beat_s  = '0;
          end else begin
            beat_s = beat_r + BEAT_W'(1);
          end
        end
        NEXT: begin
          pass_s = pass_inc_s;
          beat_s = '0;
          if (pass_inc_s < passes_r) begin
            state_s = STREAM;
          end else begin
            state_s = SETTLE;
          end
        end
        SETTLE: begin
          if (beat_r == BEAT_W'(1)) begin
            state_s = DONE;
            beat_s  = '0;
          end else begin
            beat_s = beat_r + BEAT_W'(1);
          end
        end
        DONE: begin
          state_s = IDLE;
          pass_s  = '0;
          beat_s  = '0;
        end
        default: begin
          state_s = IDLE;
          pass_s  = '0;
          beat_s  = '0;
        end
      endcase
    end
  end

  // Output values for the upcoming cycle, derived from the next state so outputs can be registered
  always_comb begin
    busy_s  = (state_s != IDLE);
    done_s  = (state_s == DONE);
    rd_en_s = (state_s == STREAM);
    mac_s   = (state_s == STREAM) || (state_s == DRAIN);
    clear_s = (state_s == CLEAR) || abort_hit_s;
    sel_s   = (state_s != STREAM);
    if (state_s == STREAM) begin
      act_addr_s = act_base_s + ADDR_W'(pass_s) * ADDR_W'(BN_NUM) + ADDR_W'(beat_s);
      wet_addr_s = wet_base_s + ADDR_W'(pass_s);
    end else begin
      act_addr_s = '0;
      wet_addr_s = '0;
    end
  end

  // State, counters, configuration latches and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      pass_r     <= '0;
      beat_r     <= '0;
      passes_r   <= '0;
      act_base_r <= '0;
      wet_base_r <= '0;
      shift_r    <= 8'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      rd_en_r    <= 1'b0;
      mac_r      <= 1'b0;
      clear_r    <= 1'b0;
      sel_r      <= 1'b1;
      act_addr_r <= '0;
      wet_addr_r <= '0;
    end else begin
      state_r    <= state_s;
      pass_r     <= pass_s;
      beat_r     <= beat_s;
      passes_r   <= passes_s;
      act_base_r <= act_base_s;
      wet_base_r <= wet_base_s;
      shift_r    <= shift_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      rd_en_r    <= rd_en_s;
      mac_r      <= mac_s;
      clear_r    <= clear_s;
      sel_r      <= sel_s;
      act_addr_r <= act_addr_s;
      wet_addr_r <= wet_addr_s;
    end
  end

  assign busy                  = busy_r;
  assign done                  = done_r;
  assign result_valid          = done_r;
  assign act_rd_en             = rd_en_r;
  assign wet_rd_en             = rd_en_r;
  assign act_rd_addr           = act_addr_r;
  assign wet_rd_addr           = wet_addr_r;
  assign PE_mac_enable         = mac_r;
  assign PE_clear_acc          = clear_r;
  assign PE_weight_partial_sel = sel_r;
  assign PE_res_shift_num      = shift_r;

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] perf_r;

  // Saturating busy-cycle counter, restarted by every accepted job
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_r <= 32'd0;
    end else if (start_accept_s) begin
      perf_r <= 32'd0;
    end else if (busy_r && (perf_r != 32'hFFFF_FFFF)) begin
      perf_r <= perf_r + 32'd1;
    end else begin
      perf_r <= perf_r;
    end
  end

  assign perf_busy_cycles = perf_r;
`else
  assign perf_busy_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// Randomized self-checking bench for systolic_tile_sequencer; expectations come from a
// per-job reference schedule (address lists, latency formula, busy window).
module tb_systolic_tile_sequencer;

  localparam int BM = 4, BN = 4, ACCU = 5, AW = 10, PW = 8;
  localparam int DRAIN = ACCU + BN + BM + 1;

  logic          clk = 1'b0;
  logic          reset_n, start, abort;
  logic [PW-1:0] cfg_passes;
  logic [AW-1:0] cfg_act_base, cfg_wet_base;
  logic [7:0]    cfg_shift;
  logic          busy, done, act_rd_en, wet_rd_en, PE_mac_enable, PE_clear_acc;
  logic          PE_weight_partial_sel, result_valid;
  logic [AW-1:0] act_rd_addr, wet_rd_addr;
  logic [7:0]    PE_res_shift_num;
  logic [31:0]   perf_busy_cycles;

  int pass_cnt = 0;
  int total_cnt = 0;

  systolic_tile_sequencer #(.BM_NUM(BM), .BN_NUM(BN), .ACCU_NUM(ACCU), .ADDR_W(AW), .PASS_W(PW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .cfg_passes(cfg_passes), .cfg_act_base(cfg_act_base), .cfg_wet_base(cfg_wet_base),
    .cfg_shift(cfg_shift), .busy(busy), .done(done),
    .act_rd_en(act_rd_en), .act_rd_addr(act_rd_addr),
    .wet_rd_en(wet_rd_en), .wet_rd_addr(wet_rd_addr),
    .PE_mac_enable(PE_mac_enable), .PE_clear_acc(PE_clear_acc),
    .PE_weight_partial_sel(PE_weight_partial_sel), .PE_res_shift_num(PE_res_shift_num),
    .result_valid(result_valid), .perf_busy_cycles(perf_busy_cycles)
  );

  always #5 clk = ~clk;

  // Idle output pattern shared by reset and post-abort checks
  function automatic logic [7:0] idle_vec();
    return {busy, done, act_rd_en, wet_rd_en, PE_mac_enable, PE_clear_acc,
            PE_weight_partial_sel, result_valid};
  endfunction

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_passes = '0; cfg_act_base = '0; cfg_wet_base = '0; cfg_shift = 8'd0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({idle_vec(), act_rd_addr, wet_rd_addr, PE_res_shift_num, perf_busy_cycles} !==
        {8'b0000_0010, 10'd0, 10'd0, 8'd0, 32'd0})
      $display("FAIL reset_outputs: got ctl=%b shift=%0d perf=%0d, want ctl=00000010 shift=0 perf=0",
               idle_vec(), PE_res_shift_num, perf_busy_cycles);
    else pass_cnt++;
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // Runs one job from IDLE and checks the full cycle-by-cycle schedule against the model
  task automatic run_job(input string name, input int p, input int ab, input int wb,
                         input logic [7:0] sh, input bit disturb);
    int pe, lat, done_off, done_n, clr_n, mac_n, strm_n, busy_bad, addr_bad, shift_bad, rv_bad;
    logic [AW-1:0] qa[$];
    logic [AW-1:0] qw[$];
    logic [AW-1:0] ea, ew;
    logic [31:0] perf_exp, perf_seen;
    pe = (p == 0) ? 1 : p;
    lat = 1 + pe * (BN + DRAIN + 1) + 2 + 1;
    for (int k = 0; k < pe; k++)
      for (int b = 0; b < BN; b++) begin
        qa.push_back(AW'((ab + k * BN + b) % 1024));
        qw.push_back(AW'((wb + k) % 1024));
      end
`ifdef SEQ_PERF_CNT_EN
    perf_exp = 32'(lat);
`else
    perf_exp = 32'd0;
`endif
    done_off = -1; done_n = 0; clr_n = 0; mac_n = 0; strm_n = 0;
    busy_bad = 0; addr_bad = 0; shift_bad = 0; rv_bad = 0; perf_seen = 32'hDEAD_BEEF;
    cfg_passes = PW'(p); cfg_act_base = AW'(ab); cfg_wet_base = AW'(wb); cfg_shift = sh;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int off = 1; off <= lat + 2; off++) begin
      if (busy !== (off <= lat)) busy_bad++;
      if (result_valid !== done) rv_bad++;
      if (done === 1'b1) begin done_n++; done_off = off; end
      if (PE_clear_acc === 1'b1) clr_n++;
      if (PE_mac_enable === 1'b1) mac_n++;
      if (PE_weight_partial_sel === 1'b0) strm_n++;
      if (act_rd_en !== wet_rd_en || act_rd_en !== ~PE_weight_partial_sel) addr_bad++;
      if (off <= lat && PE_res_shift_num !== sh) shift_bad++;
      if (act_rd_en === 1'b1) begin
        if (qa.size() == 0) addr_bad++;
        else begin
          ea = qa.pop_front(); ew = qw.pop_front();
          if (act_rd_addr !== ea || wet_rd_addr !== ew) addr_bad++;
        end
      end
      if (off == lat + 1) perf_seen = perf_busy_cycles;
      if (disturb && off == 5) begin
        start = 1'b1; cfg_passes = PW'($urandom); cfg_act_base = AW'($urandom);
        cfg_wet_base = AW'($urandom); cfg_shift = 8'($urandom);
      end
      if (off == 6) start = 1'b0;
      @(negedge clk);
    end
    total_cnt++;
    if (done_off !== lat || done_n !== 1)
      $display("FAIL %s done_cycle: got offset %0d (%0d pulses), want %0d (1 pulse)", name, done_off, done_n, lat);
    else pass_cnt++;
    total_cnt++;
    if (addr_bad !== 0 || qa.size() !== 0)
      $display("FAIL %s read_addrs: got %0d bad beats, %0d missing, want 0/0", name, addr_bad, qa.size());
    else pass_cnt++;
    total_cnt++;
    if (clr_n !== 1 || mac_n !== pe * (BN + DRAIN) || strm_n !== pe * BN)
      $display("FAIL %s pe_ctrl: got clear=%0d mac=%0d stream=%0d, want 1/%0d/%0d",
               name, clr_n, mac_n, strm_n, pe * (BN + DRAIN), pe * BN);
    else pass_cnt++;
    total_cnt++;
    if (busy_bad !== 0 || rv_bad !== 0 || shift_bad !== 0)
      $display("FAIL %s busy_shift: got busy_err=%0d rv_err=%0d shift_err=%0d, want 0", name, busy_bad, rv_bad, shift_bad);
    else pass_cnt++;
    total_cnt++;
    if (perf_seen !== perf_exp)
      $display("FAIL %s perf: got %0d, want %0d", name, perf_seen, perf_exp);
    else pass_cnt++;
  endtask

  task automatic test_directed();
    run_job("single_pass", 1, 16'h10, 16'h20, 8'd3, 1'b0);
    run_job("three_pass", 3, 16'h10, 16'h20, 8'd7, 1'b0);
    run_job("zero_pass", 0, 16'h10, 16'h20, 8'd1, 1'b0);
  endtask

  task automatic test_back_to_back_wrap();
    run_job("wrap_busy_start", 2, 16'h3FE, 16'h3FF, 8'd9, 1'b1);
  endtask

  task automatic test_random();
    for (int j = 0; j < 5; j++)
      run_job($sformatf("rand%0d", j), int'($urandom_range(0, 4)), int'($urandom_range(0, 1023)),
              int'($urandom_range(0, 1023)), 8'($urandom), 1'($urandom));
  endtask

  task automatic test_abort();
    int bad;
    cfg_passes = 8'd3; cfg_act_base = 10'h10; cfg_wet_base = 10'h20; cfg_shift = 8'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int off = 1; off < 30; off++) @(negedge clk);
    abort = 1'b1;
    total_cnt++;
    if (busy !== 1'b1 || PE_mac_enable !== 1'b1 || act_rd_en !== 1'b0)
      $display("FAIL abort_pre_drain: got busy=%b mac=%b rd=%b, want 1/1/0", busy, PE_mac_enable, act_rd_en);
    else pass_cnt++;
    @(negedge clk);
    abort = 1'b0;
    total_cnt++;
    if (idle_vec() !== 8'b0000_0110)
      $display("FAIL abort_cycle: got ctl=%b, want 00000110", idle_vec());
    else pass_cnt++;
    bad = 0;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (idle_vec() !== 8'b0000_0010) bad++;
    end
    total_cnt++;
    if (bad !== 0) $display("FAIL abort_quiet: got %0d non-idle cycles, want 0", bad);
    else pass_cnt++;
    run_job("after_abort", 2, 16'h40, 16'h50, 8'd4, 1'b0);
  endtask

  task automatic test_mid_reset();
    int bad;
    cfg_passes = 8'd2; cfg_act_base = 10'h33; cfg_wet_base = 10'h44; cfg_shift = 8'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    reset_n = 1'b0;
    #1;
    total_cnt++;
    if ({idle_vec(), PE_res_shift_num, perf_busy_cycles} !== {8'b0000_0010, 8'd0, 32'd0})
      $display("FAIL mid_reset: got ctl=%b shift=%0d perf=%0d, want 00000010/0/0",
               idle_vec(), PE_res_shift_num, perf_busy_cycles);
    else pass_cnt++;
    @(negedge clk);
    reset_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) bad++;
    end
    total_cnt++;
    if (bad !== 0) $display("FAIL mid_reset_no_done: got %0d active cycles, want 0", bad);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back_wrap();
    test_random();
    test_abort();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
